// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1-2 stop bits) with a FWFT frame FIFO.
// Frame visible 2+1+HALF+(bits)*BIT_TIME+1 cycles after start edge; consumer stalls via rx_ready, a full FIFO drops new frames and pulses overrun.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 230400,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_perr,
  output logic                         rx_ferr,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BIT_TIME / 2;
  localparam int CW       = $clog2(BIT_TIME) + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_BIT   = CW'(BIT_TIME - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(HALF - 1);
  localparam logic [3:0]    C_DBITS = 4'(DATA_BITS - 1);
  localparam logic [3:0]    C_SBITS = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE} state_t;

  state_t                 r_state;
  logic                   r_sync1, r_rxs, r_rxs_d;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_nbit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr, r_ferr;
  logic                   r_push, r_push_perr, r_push_ferr;
  logic [DATA_BITS-1:0]   r_push_dat;

  logic w_tick, w_xor, w_par_err, w_stop_err;
  assign w_tick     = (r_cnt == '0);
  assign w_xor      = (^r_shift) ^ r_rxs;
  assign w_par_err  = (PARITY == 1) ? ~w_xor : w_xor;
  assign w_stop_err = r_ferr | ~r_rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_rxs_d     <= 1'b1;
      r_cnt       <= '0;
      r_nbit      <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_push      <= 1'b0;
      r_push_dat  <= '0;
      r_push_perr <= 1'b0;
      r_push_ferr <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
      r_push  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rxs && r_rxs_d) begin
            r_cnt   <= C_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= C_BIT;
            r_nbit  <= C_DBITS;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_state <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= C_BIT;
            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_nbit == '0) begin
              r_nbit  <= C_SBITS;
              r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_nbit <= r_nbit - 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_cnt   <= C_BIT;
            r_perr  <= w_par_err;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt <= C_BIT;
            if (r_nbit == '0) begin
              r_push      <= 1'b1;
              r_push_dat  <= r_shift;
              r_push_perr <= r_perr;
              r_push_ferr <= w_stop_err;
              // a low line after a bad stop is a break; wait for idle before rearming
              r_state     <= w_stop_err ? S_WAIT_IDLE : S_IDLE;
            end else begin
              r_ferr <= w_stop_err;
              r_nbit <= r_nbit - 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS+1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_count;
  logic                 r_ovr;
  logic                 w_pop, w_full, w_wr_en;

  assign w_pop   = rx_valid && rx_ready;
  assign w_full  = (r_count == C_DEPTH);
  assign w_wr_en = r_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= r_push && w_full && !w_pop;
      if (w_wr_en) begin
        r_mem[r_wr] <= {r_push_perr, r_push_ferr, r_push_dat};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr_en && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign {rx_perr, rx_ferr, rx_data} = r_mem[r_rd];
  assign rx_valid   = (r_count != '0);
  assign overrun    = r_ovr;
  assign fifo_count = r_count;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance (a) and a 7E1 instance (b) at BIT_TIME = 10, HALF = 5.
module tb_uart_rx_cfg;
  localparam int BT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic       a_perr, a_ferr, a_valid, a_ovr;
  logic       b_perr, b_ferr, b_valid, b_ovr;
  logic [2:0] a_cnt, b_cnt;

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(a_data), .rx_perr(a_perr),
    .rx_ferr(a_ferr), .rx_valid(a_valid), .rx_ready(rdy_a), .overrun(a_ovr),
    .fifo_count(a_cnt));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(b_data), .rx_perr(b_perr),
    .rx_ferr(b_ferr), .rx_valid(b_valid), .rx_ready(rdy_b), .overrun(b_ovr),
    .fifo_count(b_cnt));

  int checks = 0;
  int failures = 0;
  logic [10:0] q_a[$], q_b[$];
  int ovr_a = 0, vld_a = 0;

  // Consumer side: every accepted head frame, as {perr, ferr, data}.
  always @(negedge clk) begin
    if (a_valid && rdy_a) q_a.push_back({a_perr, a_ferr, 1'b0, a_data});
    if (b_valid && rdy_b) q_b.push_back({b_perr, b_ferr, 2'b00, b_data});
    if (a_ovr) ovr_a++;
    if (a_valid) vld_a++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] fa(input logic [7:0] d, input logic pe, input logic fe);
    return {pe, fe, 1'b0, d};
  endfunction

  function automatic logic [10:0] fb(input logic [6:0] d, input logic pe, input logic fe);
    return {pe, fe, 2'b00, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Serialises start, nb data bits LSB first, optional parity (1 odd, 2 even), one stop bit.
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nb, input int par,
                            input bit flip, input bit bad_stop);
    logic p;
    p = 1'b0;
    set_line(sel, 1'b0);
    tick(BT);
    for (int i = 0; i < nb; i++) begin
      set_line(sel, d[i]);
      p = p ^ d[i];
      tick(BT);
    end
    if (par != 0) begin
      set_line(sel, ((par == 1) ? ~p : p) ^ flip);
      tick(BT);
    end
    set_line(sel, ~bad_stop);
    tick(BT);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    tick(3);
    checks++;
    if ({a_valid, a_perr, a_ferr, a_ovr, a_cnt, a_data} !== 15'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {a_valid, a_perr, a_ferr, a_ovr, a_cnt, a_data});
    end
    checks++;
    if ({b_valid, b_perr, b_ferr, b_ovr, b_cnt, b_data} !== 14'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", {b_valid, b_perr, b_ferr, b_ovr, b_cnt, b_data});
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_latency;
    int k;
    k = 0;
    q_a.delete(); vld_a = 0; rdy_a = 1'b1;
    fork
      send_frame(1'b0, 9'h0A5, 8, 0, 1'b0, 1'b0);
      begin
        while (a_valid !== 1'b1 && k < 300) begin
          @(posedge clk); #1; k++;
        end
      end
    join
    tick(20);
    checks++;
    if (k !== 2 + 1 + 5 + (8 + 0 + 1) * BT + 1) begin
      failures++;
      $display("FAIL latency got=%0d exp=%0d", k, 2 + 1 + 5 + 9 * BT + 1);
    end
    checks++;
    if (vld_a !== 1) begin
      failures++;
      $display("FAIL valid_width got=%0d exp=1", vld_a);
    end
    checks++;
    if (q_a.size() !== 1) begin
      failures++;
      $display("FAIL a5_count got=%0d exp=1", q_a.size());
    end else begin
      checks++;
      if (q_a[0] !== fa(8'hA5, 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL a5_frame got=%h exp=%h", q_a[0], fa(8'hA5, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_parity;
    logic [10:0] exp_q[$];
    q_b.delete(); rdy_b = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_frame(1'b1, 9'h035, 7, 2, f[0], 1'b0);
      exp_q.push_back(fb(7'h35, f[0], 1'b0));
    end
    tick(20);
    checks++;
    if (q_b.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL parity_count got=%0d exp=%0d", q_b.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL parity_frame%0d got=%h exp=%h", i, q_b[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_framing;
    q_a.delete(); rdy_a = 1'b1;
    send_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1'b1);
    tick(30);
    checks++;
    if (q_a.size() !== 1) begin
      failures++;
      $display("FAIL break_count got=%0d exp=1", q_a.size());
    end else begin
      checks++;
      if (q_a[0] !== fa(8'h3C, 1'b0, 1'b1)) begin
        failures++;
        $display("FAIL ferr_frame got=%h exp=%h", q_a[0], fa(8'h3C, 1'b0, 1'b1));
      end
    end
    set_line(1'b0, 1'b1);
    tick(20);
    send_frame(1'b0, 9'h055, 8, 0, 1'b0, 1'b0);
    tick(20);
    checks++;
    if (q_a.size() !== 2) begin
      failures++;
      $display("FAIL after_break_count got=%0d exp=2", q_a.size());
    end else begin
      checks++;
      if (q_a[1] !== fa(8'h55, 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL after_break_frame got=%h exp=%h", q_a[1], fa(8'h55, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_glitch;
    q_a.delete(); vld_a = 0; rdy_a = 1'b1;
    set_line(1'b0, 1'b0);
    tick(4);
    set_line(1'b0, 1'b1);
    tick(30);
    checks++;
    if (vld_a !== 0 || q_a.size() !== 0) begin
      failures++;
      $display("FAIL glitch got valid_cycles=%0d frames=%0d exp=0,0", vld_a, q_a.size());
    end
    send_frame(1'b0, 9'h05A, 8, 0, 1'b0, 1'b0);
    tick(20);
    checks++;
    if (q_a.size() !== 1 || q_a[0] !== fa(8'h5A, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL post_glitch got frames=%0d head=%h exp=1,%h",
               q_a.size(), (q_a.size() > 0) ? q_a[0] : 11'h0, fa(8'h5A, 1'b0, 1'b0));
    end
  endtask

  task automatic test_overrun;
    int nsent;
    nsent = 5;
    q_a.delete(); ovr_a = 0; rdy_a = 1'b0;
    for (int v = 1; v <= nsent; v++) send_frame(1'b0, 9'(v), 8, 0, 1'b0, 1'b0);
    tick(20);
    checks++;
    if (a_cnt !== 3'd4) begin
      failures++;
      $display("FAIL full_count got=%0d exp=4", a_cnt);
    end
    checks++;
    if (ovr_a !== nsent - 4) begin
      failures++;
      $display("FAIL overrun_pulses got=%0d exp=%0d", ovr_a, nsent - 4);
    end
    tick(7);
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h01) begin
      failures++;
      $display("FAIL stall_head got valid=%b data=%h exp=1,01", a_valid, a_data);
    end
    rdy_a = 1'b1;
    tick(10);
    checks++;
    if (q_a.size() !== 4 || a_cnt !== 3'd0) begin
      failures++;
      $display("FAIL drain got frames=%0d count=%0d exp=4,0", q_a.size(), a_cnt);
    end
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== fa(8'(i + 1), 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL drain_order%0d got=%h exp=%h", i, q_a[i], fa(8'(i + 1), 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] ea[$], eb[$];
    bit done;
    done = 1'b0;
    q_a.delete(); q_b.delete(); rdy_b = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] d;
          d = 8'($urandom_range(0, 255));
          ea.push_back(fa(d, 1'b0, 1'b0));
          send_frame(1'b0, {1'b0, d}, 8, 0, 1'b0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          logic [6:0] d;
          logic fl;
          d  = 7'($urandom_range(0, 127));
          fl = 1'($urandom_range(0, 1));
          eb.push_back(fb(d, fl, 1'b0));
          send_frame(1'b1, {2'b00, d}, 7, 2, fl, 1'b0);
        end
      end
      begin
        while (!done) begin
          rdy_a = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rdy_a = 1'b1;
    tick(20);
    checks++;
    if (q_a.size() !== ea.size() || q_b.size() !== eb.size()) begin
      failures++;
      $display("FAIL b2b_counts got=%0d,%0d exp=%0d,%0d", q_a.size(), q_b.size(), ea.size(), eb.size());
    end
    for (int i = 0; i < ea.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== ea[i]) begin
        failures++;
        $display("FAIL b2b_a%0d got=%h exp=%h", i, q_a[i], ea[i]);
      end
    end
    for (int i = 0; i < eb.size() && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== eb[i]) begin
        failures++;
        $display("FAIL b2b_b%0d got=%h exp=%h", i, q_b[i], eb[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    q_a.delete(); rdy_a = 1'b0;
    send_frame(1'b0, 9'h011, 8, 0, 1'b0, 1'b0);
    send_frame(1'b0, 9'h022, 8, 0, 1'b0, 1'b0);
    tick(5);
    checks++;
    if (a_cnt !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset_count got=%0d exp=2", a_cnt);
    end
    set_line(1'b0, 1'b0); tick(BT);
    set_line(1'b0, 1'b1); tick(BT);
    set_line(1'b0, 1'b0); tick(5);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({a_valid, a_perr, a_ferr, a_ovr, a_cnt, a_data} !== 15'h0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0", {a_valid, a_perr, a_ferr, a_ovr, a_cnt, a_data});
    end
    set_line(1'b0, 1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (a_valid !== 1'b0 || a_cnt !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_idle got valid=%b count=%0d exp=0,0", a_valid, a_cnt);
    end
    rdy_a = 1'b1;
    send_frame(1'b0, 9'h081, 8, 0, 1'b0, 1'b0);
    tick(20);
    checks++;
    if (q_a.size() !== 1 || q_a[0] !== fa(8'h81, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL post_reset_frame got frames=%0d head=%h exp=1,%h",
               q_a.size(), (q_a.size() > 0) ? q_a[0] : 11'h0, fa(8'h81, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver feeding the echo path. It supports configurable data width, parity and stop bits, and validates the start bit. It reports parity and framing errors per frame and buffers received frames in a small first-word-fall-through FIFO with a valid/ready output handshake. It sits between the board RX pin and the TX/echo logic, which consumes frames at its own pace.

## Interface
- CLK_FREQ, 125000000, system clock frequency in Hz
- BAUD_RATE, 230400, line rate in bit/s; BIT_TIME = CLK_FREQ / BAUD_RATE (integer division), HALF = BIT_TIME / 2
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, frame buffer depth, power of two, at least 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  head-of-FIFO data, LSB = first bit received
- rx_perr  out  1  parity error flag of head frame, always 0 when PARITY = 0
- rx_ferr  out  1  framing error flag of head frame (a stop bit sampled 0)
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head frame when rx_valid && rx_ready
- overrun  out  1  one-cycle pulse when a completed frame is dropped
- fifo_count  out  clog2(FIFO_DEPTH)+1  frames currently held

## Operation
- rx passes through a 2-FF synchronizer (reset value 1); all decoding uses the synchronized signal rxs.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE: on a falling edge of rxs (previous 1, current 0), load the bit counter and go to START.
- START: after HALF cycles, sample rxs. If it is 1, the start was a glitch: return to IDLE with no push and no flags. If it is 0, go to DATA.
- DATA: sample every BIT_TIME cycles into the shift register, LSB first, DATA_BITS samples. Then go to PAR if PARITY != 0, else STOP.
- PAR: one sample after BIT_TIME. perr = 1 when (XOR of data bits XOR parity bit) != 1 for odd, or != 0 for even.
- STOP: STOP_BITS samples, each BIT_TIME apart. ferr = 1 if any stop sample is 0.
- On the final stop sample edge: push {data, perr, ferr} into the FIFO. Frames with errors are still pushed, with their flags set.
  - If ferr = 0, go to IDLE.
  - If ferr = 1, go to WAIT_IDLE, which holds until rxs = 1 and then enters IDLE. This prevents a break condition from being read as repeated frames.
- FIFO push/pop:
  - Pop on rx_valid && rx_ready.
  - Push when full without a same-cycle pop: frame dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty-to-one is not possible, because outputs are registered: a frame is visible only from the cycle after its push.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH.

## Timing
- Reset values:
  - rx_data = 0, rx_perr = 0, rx_ferr = 0, rx_valid = 0, overrun = 0, fifo_count = 0.
  - FSM in IDLE, synchronizer = 1, FIFO pointers = 0.
- Reset asserted mid-frame aborts the frame immediately, and FIFO contents are discarded. After release, reception resumes only on a new falling edge of rxs.
- Latency, rx pin falling edge to rx_valid = 1 with the FIFO previously empty: 2 (sync) + 1 (edge detect) + HALF + (DATA_BITS + (PARITY != 0) + STOP_BITS) × BIT_TIME + 1 cycles.
- rx_data, rx_perr and rx_ferr are stable while rx_valid = 1 and rx_ready = 0. After a pop, the next entry, if any, is presented on the following cycle.
- Back-to-back frames: the next start edge is accepted in the cycle after the STOP→IDLE transition. The minimum one-stop-bit gap at the nominal rate is tolerated.
- The bit counter width is clog2(BIT_TIME)+1. No other arithmetic wider than the counter is used.

## Test plan
Bench parameters: CLK_FREQ = 1000000, BAUD_RATE = 100000, so BIT_TIME = 10 and HALF = 5.
- 8N1, send 0xA5 with rx_ready = 1 → rx_valid for 1 cycle with rx_data = 0xA5, perr = 0, ferr = 0, at the latency computed above.
- PARITY = 2 (even), DATA_BITS = 7: send 0x35 with a correct parity bit, then 0x35 with the parity bit flipped → two frames, perr = 0 then perr = 1, data = 0x35 both.
- 8N1, send 0x3C with a stop bit of 0, then hold rx low for 30 cycles → one frame with ferr = 1, no further frames until rx returns high; then 0x55 is received cleanly.
- 4-cycle low glitch on idle rx → no push, FSM back in IDLE, rx_valid stays 0.
- FIFO_DEPTH = 4, rx_ready = 0, send 0x01..0x05 → fifo_count = 4, overrun pulses once on the 5th frame; raising rx_ready then pops 0x01, 0x02, 0x03, 0x04 in order.
- Assert rst_n low in the middle of the DATA state while 2 frames are buffered → all outputs return to reset values; the next full frame 0x81 is received correctly.
